// File: rtl/wshb_frame_reader.sv
`default_nettype none
//==============================================================================
// Module      : wshb_frame_reader
// Description : Wishbone read master that sweeps a framebuffer in raster order
//               and pushes every pixel word into the write side of the pixel
//               FIFO feeding the display stage. A fixed-length transaction is
//               started whenever the FIFO reports enough room; transactions
//               never cross a frame end, and the sweep wraps forever. A
//               start-of-frame flag accompanies pixel 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   HDISP      active pixels per line
//   VDISP      active lines per frame
//   BASE_ADDR  byte address of pixel 0
//   BURST_LEN  beats per transaction (>= 1)
// Ports
//   sys_clk            system clock
//   sys_rst            asynchronous active-high reset
//   wshb_*_o / wshb_*_i  Wishbone master signals (32-bit data, read-only use)
//   fifo_walmost_full  FIFO has fewer than BURST_LEN+2 free slots
//   fifo_write         FIFO write strobe
//   fifo_wdata         pixel word written to the FIFO
//   fifo_wsof          word is pixel 0 of a frame (qualified by fifo_write)
// Build option
//   WSHB_BURST_EN      when defined, cti signals incrementing bursts
//                      (3'b010 ... 3'b111); otherwise classic cycles (3'b000)
//==============================================================================
module wshb_frame_reader #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          BURST_LEN = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    // Wishbone master
    output logic        wshb_cyc_o,
    output logic        wshb_stb_o,
    output logic        wshb_we_o,
    output logic [3:0]  wshb_sel_o,
    output logic [31:0] wshb_adr_o,
    output logic [31:0] wshb_dat_ms_o,
    output logic [2:0]  wshb_cti_o,
    output logic [1:0]  wshb_bte_o,
    input  logic [31:0] wshb_dat_sm_i,
    input  logic        wshb_ack_i,
    input  logic        wshb_err_i,
    input  logic        wshb_rty_i,
    // Pixel FIFO write side
    input  logic        fifo_walmost_full,
    output logic        fifo_write,
    output logic [31:0] fifo_wdata,
    output logic        fifo_wsof
);

    localparam int TOTAL = HDISP * VDISP;
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int LW    = $clog2(BURST_LEN + 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [LW-1:0]   beat_q;
    logic [LW-1:0]   len_q;
    logic            cyc_q;
    logic [2:0]      cti_q;
    logic            fifo_write_q;
    logic [31:0]     fifo_wdata_q;
    logic            fifo_wsof_q;

    logic [IW-1:0]   idx_d;
    logic [LW-1:0]   len_d;
    int              remain_d;
    logic            last_beat_d;
    logic            accept_d;
    logic [2:0]      cti_start_d;
    logic [2:0]      cti_next_d;

    //--------------------------------------------------------------------------
    // Next-value helpers
    //--------------------------------------------------------------------------
    always_comb begin
        // Pixel index advances with wrap at the frame end.
        idx_d = (idx_q == IW'(TOTAL - 1)) ? '0 : idx_q + IW'(1);

        // Transaction length is clipped so a burst never spans two frames.
        remain_d = TOTAL - int'(idx_q);
        len_d    = (remain_d < BURST_LEN) ? LW'(remain_d) : LW'(BURST_LEN);

        last_beat_d = (beat_q == len_q - LW'(1));

        // err completes a beat just like ack; rty alone only repeats it.
        accept_d = wshb_ack_i | wshb_err_i;

`ifdef WSHB_BURST_EN
        cti_start_d = (len_d == LW'(1)) ? CTI_END : CTI_INCR;
        // cti for the beat following the current one (only used when the
        // current beat is not the last).
        cti_next_d  = (beat_q + LW'(1) == len_q - LW'(1)) ? CTI_END : CTI_INCR;
`else
        cti_start_d = CTI_CLASSIC;
        cti_next_d  = CTI_CLASSIC;
`endif
    end

    //--------------------------------------------------------------------------
    // Transaction FSM with registered bus and FIFO outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            beat_q       <= '0;
            len_q        <= '0;
            cyc_q        <= 1'b0;
            cti_q        <= CTI_CLASSIC;
            fifo_write_q <= 1'b0;
            fifo_wdata_q <= '0;
            fifo_wsof_q  <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted beat.
            fifo_write_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // The FIFO owner guarantees BURST_LEN+2 slots whenever the
                    // flag is low, so a whole transaction fits.
                    if (!fifo_walmost_full) begin
                        state_q <= S_READ;
                        cyc_q   <= 1'b1;
                        len_q   <= len_d;
                        beat_q  <= '0;
                        cti_q   <= cti_start_d;
                    end
                end

                S_READ: begin
                    // The almost-full flag is not looked at here: a started
                    // transaction always runs to completion.
                    if (accept_d) begin
                        fifo_write_q <= 1'b1;
                        // ack has priority over err; an err beat still
                        // occupies its raster position but carries zero.
                        fifo_wdata_q <= wshb_ack_i ? wshb_dat_sm_i : 32'h0;
                        fifo_wsof_q  <= (idx_q == '0);
                        idx_q        <= idx_d;
                        if (last_beat_d) begin
                            state_q <= S_IDLE;
                            cyc_q   <= 1'b0;
                            beat_q  <= '0;
                            cti_q   <= CTI_CLASSIC;
                        end else begin
                            beat_q  <= beat_q + LW'(1);
                            cti_q   <= cti_next_d;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    cti_q   <= CTI_CLASSIC;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Output mapping
    //--------------------------------------------------------------------------
    // Address comes straight from the index register, so it moves on the edge
    // of each accepted beat and stays put across retries.
    assign wshb_adr_o    = BASE_ADDR + 32'({idx_q, 2'b00});
    assign wshb_cyc_o    = cyc_q;
    assign wshb_stb_o    = cyc_q;
    assign wshb_cti_o    = cti_q;
    assign wshb_we_o     = 1'b0;
    assign wshb_sel_o    = 4'hF;
    assign wshb_dat_ms_o = 32'h0;
    assign wshb_bte_o    = 2'b00;

    assign fifo_write    = fifo_write_q;
    assign fifo_wdata    = fifo_wdata_q;
    assign fifo_wsof     = fifo_wsof_q;

endmodule
`default_nettype wire

// File: tb/tb_wshb_frame_reader.sv
`default_nettype none
//==============================================================================
// Module      : tb_wshb_frame_reader
// Description : Randomized self-checking bench for wshb_frame_reader. A small
//               frame (8x3 pixels, 5-beat bursts) makes frame wraps and the
//               clipped last transaction frequent. Wishbone responses and the
//               FIFO almost-full flag are randomized; a transaction-level model
//               predicts bus and FIFO outputs every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_wshb_frame_reader;

    localparam int          HD    = 8;
    localparam int          VD    = 3;
    localparam int          BL    = 5;
    localparam int          TOTAL = HD * VD;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NCYC  = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm = '0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic        af = 1'b1;
    logic        fw, fsof;
    logic [31:0] fdata;

    always #5 clk = ~clk;

    wshb_frame_reader #(
        .HDISP    (HD),
        .VDISP    (VD),
        .BASE_ADDR(BASE),
        .BURST_LEN(BL)
    ) dut (
        .sys_clk          (clk),
        .sys_rst          (rst),
        .wshb_cyc_o       (cyc),
        .wshb_stb_o       (stb),
        .wshb_we_o        (we),
        .wshb_sel_o       (sel),
        .wshb_adr_o       (adr),
        .wshb_dat_ms_o    (dat_ms),
        .wshb_cti_o       (cti),
        .wshb_bte_o       (bte),
        .wshb_dat_sm_i    (dat_sm),
        .wshb_ack_i       (ack),
        .wshb_err_i       (err),
        .wshb_rty_i       (rty),
        .fifo_walmost_full(af),
        .fifo_write       (fw),
        .fifo_wdata       (fdata),
        .fifo_wsof        (fsof)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: whether a transaction is open, next pixel, beats left in the
    // open transaction, and the FIFO write expected after the last edge.
    bit          m_read;
    int          m_idx;
    int          m_left;
    bit          m_pend;
    logic [31:0] m_data;
    bit          m_sof;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_read = 1'b0;
        m_idx  = 0;
        m_left = 0;
        m_pend = 1'b0;
        m_data = '0;
        m_sof  = 1'b0;
    endtask

    // Applies the effect of the coming rising edge given the driven inputs.
    task automatic model_step();
        m_pend = 1'b0;
        if (m_read) begin
            if (ack || err) begin
                m_pend = 1'b1;
                m_data = ack ? dat_sm : 32'h0;
                m_sof  = (m_idx == 0);
                m_idx  = (m_idx + 1) % TOTAL;
                m_left = m_left - 1;
                if (m_left == 0) m_read = 1'b0;
            end
        end else if (!af) begin
            m_read = 1'b1;
            m_left = (TOTAL - m_idx < BL) ? (TOTAL - m_idx) : BL;
        end
    endtask

    task automatic compare();
        logic [2:0] exp_cti;
`ifdef WSHB_BURST_EN
        exp_cti = m_read ? ((m_left == 1) ? 3'b111 : 3'b010) : 3'b000;
`else
        exp_cti = 3'b000;
`endif
        check("cyc", {31'b0, cyc}, {31'b0, m_read});
        check("stb", {31'b0, stb}, {31'b0, m_read});
        check("adr", adr, BASE + 32'(m_idx * 4));
        check("cti", {29'b0, cti}, {29'b0, exp_cti});
        check("const", {we, sel, dat_ms[3:0], bte}, {1'b0, 4'hF, 4'h0, 2'b00});
        check("fifo_write", {31'b0, fw}, {31'b0, m_pend});
        if (m_pend) begin
            check("fifo_wdata", fdata, m_data);
            check("fifo_wsof", {31'b0, fsof}, {31'b0, m_sof});
        end
    endtask

    task automatic drive_idle();
        ack = 1'b0; err = 1'b0; rty = 1'b0; af = 1'b1; dat_sm = '0;
    endtask

    task automatic drive_random(input int k);
        int r;
        int pct;
        case ((k / 300) % 3)
            0:       pct = 10;
            1:       pct = 50;
            default: pct = 90;
        endcase
        af     = ($urandom_range(0, 99) < pct);
        dat_sm = $urandom;
        if (m_read) begin
            r   = $urandom_range(0, 15);
            ack = (r < 9) || (r == 12);
            err = (r == 9) || (r == 10) || (r == 12);
            rty = (r >= 11) && (r <= 14);
        end else begin
            ack = 1'b0; err = 1'b0; rty = 1'b0;
        end
    endtask

    initial begin
        int hold;
        int n_rst;
        hold  = 0;
        n_rst = 0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        check("pin_rst_adr", adr, 32'h0000_1000);

        // Release reset and open with a directed full-speed burst.
        rst = 1'b0;
        af  = 1'b0;
        model_step();

        for (int k = 1; k <= NCYC; k++) begin
            @(negedge clk);
            compare();

            // Literal expectations for the opening burst.
            if (k == 1) begin
                check("pin_first_cyc", {31'b0, cyc}, 32'd1);
                check("pin_first_adr", adr, 32'h0000_1000);
            end
            if (k == 2) begin
                check("pin_beat0_adr", adr, 32'h0000_1004);
                check("pin_beat0_data", fdata, 32'h0000_00A0);
                check("pin_beat0_sof", {31'b0, fsof}, 32'd1);
            end
            if (k == 6) begin
                check("pin_end_cyc", {31'b0, cyc}, 32'd0);
                check("pin_beat4_data", fdata, 32'h0000_00A4);
                check("pin_beat4_sof", {31'b0, fsof}, 32'd0);
                check("pin_end_adr", adr, 32'h0000_1014);
            end

            if (rst) begin
                hold--;
                if (hold == 0) begin
                    rst = 1'b0;
                end else begin
                    drive_idle();
                    continue;
                end
            end else if (n_rst < 2 && k >= 1200 * (n_rst + 1) && m_read && m_left == 2) begin
                // Asynchronous reset in the middle of a burst, between edges.
                n_rst++;
                drive_idle();
                #2 rst = 1'b1;
                #1;
                check("rst_async_cyc", {31'b0, cyc}, 32'd0);
                check("rst_async_write", {31'b0, fw}, 32'd0);
                check("rst_async_adr", adr, BASE);
                check("rst_async_cti", {29'b0, cti}, 32'd0);
                check("rst_async_wdata", fdata, 32'd0);
                check("rst_async_wsof", {31'b0, fsof}, 32'd0);
                model_reset();
                hold = 2;
                continue;
            end

            if (k <= 5) begin
                af     = 1'b0;
                ack    = 1'b1;
                err    = 1'b0;
                rty    = 1'b0;
                dat_sm = 32'h0000_00A0 + 32'(k - 1);
            end else begin
                drive_random(k);
            end
            model_step();
        end

        if (n_rst < 2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mid_burst_reset: got %0d resets expected 2", n_rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wshb_frame_reader.md
# wshb_frame_reader

Wishbone master that sweeps the framebuffer in SDRAM in raster order and pushes each pixel word into the write side of the pixel FIFO feeding the `vga` display stage. It runs in the system clock domain on the `wshb_if_stream` bus in `Top`, replacing the bus neutralisation there. It reads fixed-length transactions whenever the FIFO has room and wraps endlessly over frames. A start-of-frame flag travels with pixel 0 so the display side can realign after reset.

## Interface
- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `BASE_ADDR`, 32'h0, byte address of pixel 0 in SDRAM
- `BURST_LEN`, 16, beats per transaction (≥1)
- `sys_clk`  in  1  system clock, 100 MHz
- `sys_rst`  in  1  reset, asynchronous, active-high
- `wshb_ifm`  master modport  `wshb_if` with `DATA_BYTES=4`  read-only bus to SDRAM
- `fifo_walmost_full`  in  1  FIFO write side has fewer than `BURST_LEN+2` free slots
- `fifo_write`  out  1  write strobe into the FIFO
- `fifo_wdata`  out  32  pixel word
- `fifo_wsof`  out  1  marks the word as pixel 0 of a frame; valid with `fifo_write`

## Operation
- Pixel index `idx` has width `$clog2(HDISP*VDISP)`. It runs from 0 to `HDISP*VDISP-1`, then wraps to 0.
- Address: `adr = BASE_ADDR + {idx,2'b00}`, derived from registers only.
- Constant bus outputs: `we=0`, `sel=4'hF`, `dat_ms=0`, `bte=2'b00`.
- Transaction length `len = min(BURST_LEN, HDISP*VDISP - idx_at_start)`. A transaction never crosses a frame end.
- FSM:
  - IDLE: `cyc=stb=0`. If `fifo_walmost_full=0`, go to READ.
  - READ: `cyc=stb=1`.
    - On `ack`: `idx++` (with wrap) and `beat++`. On the last beat (`beat==len-1`) go to IDLE.
    - On `err`: treated exactly as `ack`, but the data word is forced to 0. This keeps the raster aligned.
    - On `rty` (without `ack` or `err`): `idx` is unchanged and `stb` stays high, so the same address is reissued.
    - Priority when flags are asserted together: `ack` > `err` > `rty`.
  - `fifo_walmost_full` is ignored inside READ. A started transaction always completes.
- FIFO write:
  - One cycle after each `ack` or `err` beat: `fifo_write=1`, `fifo_wdata` = registered `dat_sm` (or 0 on `err`).
  - `fifo_wsof=1` iff that beat's `idx` was 0.
- Reset (async):
  - State IDLE; `idx=0`, `beat=0`.
  - `cyc=stb=0`, `adr=BASE_ADDR`, `cti=3'b000`.
  - `fifo_write=0`, `fifo_wdata=0`, `fifo_wsof=0`.
  - Reset mid-transaction drops `cyc` immediately. No pending FIFO write survives reset.
  - After reset, reading restarts from pixel 0.

## Timing
- IDLE→READ: one cycle after `fifo_walmost_full` is sampled low. `cyc` is high from the following edge.
- Sustained throughput: one beat per cycle while `ack` is held high.
- Gap between transactions: one IDLE cycle minimum.
- Data latency: bus `ack` edge to `fifo_write` is 1 cycle.
- FIFO headroom requirement: `BURST_LEN+2` slots at the moment `fifo_walmost_full` is low. The FIFO owner guarantees the threshold, so `fifo_write` is never issued into a full FIFO.
- `adr` updates on the edge of the accepted beat. The next beat presents the next address in the following cycle.

## Configuration
- `WSHB_BURST_EN` defined:
  - `cti=3'b010` (incrementing burst) on every beat of a transaction except the last.
  - `cti=3'b111` on the last beat (`beat==len-1`), including `len==1`.
  - `cti=3'b000` in IDLE.
- `WSHB_BURST_EN` undefined: `cti=3'b000` always (classic cycles).
- Transaction length, addressing and FSM are identical in both builds.

## Test plan
- Reset: `sys_rst=1` asynchronously mid-cycle -> `cyc=stb=0`, `adr=0`, `fifo_write=0` immediately; after release, first `adr=0`.
- Single burst, `ack` every cycle, `fifo_walmost_full=0`, `dat_sm=idx` -> addresses 0,4,…,60; 16 `fifo_write` pulses, each one cycle after its `ack`, with data 0..15; `fifo_wsof` only on the first; with `WSHB_BURST_EN`, `cti=010`×15 then `111`.
- Flow control: raise `fifo_walmost_full` during beat 5 -> burst completes all 16 beats; FSM stays in IDLE while the flag is high; READ starts one cycle after the flag drops, with `adr=64`.
- Frame wrap with `HDISP=4`, `VDISP=2`, `BURST_LEN=3` -> transactions of 3,3,2 beats (addresses 0–8, 12–20, 24–28), then 0 again; `fifo_wsof` on pixel 0 of each frame.
- `rty` on beat 2 for 3 cycles, then `ack` -> `adr` held at 8 throughout; exactly one FIFO write for pixel 2; `err` on beat 4 -> FIFO gets data 0 and `idx` advances.
- Reset asserted mid-burst at beat 7 -> `cyc` drops asynchronously; after release the next transaction starts at `adr=0` with `fifo_wsof=1`.
